clk_glitch_responder: RTL
=========================

Name: clk_glitch_responder

Overview:
Consumer side of the clock-glitch detector. Takes the per-lane alarm vector and mismatch flag from CLK_counter and turns them into a graded core response: count events in a window, halt the cv32e40p fetch via a req/ack handshake, then pulse a core reset request. Escalates to a permanent lock after repeated incidents. Sits between CLK_counter and the core's debug/reset control.

Parameters:
NUMBER_OF_CLK, 4, number of monitored clock lanes (matches detector)
ALARM_THRESHOLD, 2, events within one window that trigger a halt (1..255)
WINDOW_CYCLES, 256, event-window length in clk cycles (power of two, >=4)
HALT_TIMEOUT, 16, max cycles waiting for halt_ack_i before forcing reset
RESET_HOLD, 8, cycles core_rst_req_o stays high
MAX_ESCALATIONS, 3, completed resets before entering LOCKED

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  enables monitoring; low in IDLE/MONITOR forces IDLE
alarm_i  in  NUMBER_OF_CLK  per-lane alarm from detector (level)
mismatch_i  in  1  detector mismatch flag (level)
clear_i  in  1  clears sticky status (alarm_src_o, alarm_count_o)
halt_ack_i  in  1  core acknowledges halt
halt_req_o  out  1  halt request to core
fetch_block_o  out  1  blocks instruction fetch
core_rst_req_o  out  1  core reset request
locked_o  out  1  permanent lockout indicator
alarm_src_o  out  NUMBER_OF_CLK  sticky OR of lanes that alarmed
alarm_count_o  out  8  total events, saturating at 255
state_o  out  3  current FSM state encoding

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, edge-detect registers 0.
- Event = rising edge of (|alarm_i | mismatch_i), registered; 1 cycle latency from input rise to counting. Held level counts once.
- States: IDLE=0, MONITOR=1, HALT=2, RESET=3, LOCKED=4.
- IDLE: en=1 -> MONITOR next cycle. Events ignored.
- MONITOR: window counter runs 0..WINDOW_CYCLES-1 and wraps; window event count clears on wrap. Event arriving in the wrap cycle counts into the new window (count becomes 1). en=0 -> IDLE, window state cleared. Window count reaching ALARM_THRESHOLD -> HALT next cycle.
- HALT: halt_req_o=1, fetch_block_o=1. halt_ack_i=1 -> RESET. No ack after HALT_TIMEOUT cycles -> RESET. Ack in the timeout cycle itself = ack path (identical result). en ignored.
- RESET: core_rst_req_o=1 for exactly RESET_HOLD cycles, fetch_block_o stays 1, halt_req_o=0. Then escalation counter +1; if it reaches MAX_ESCALATIONS -> LOCKED, else MONITOR with window state cleared.
- LOCKED: fetch_block_o=1, locked_o=1, others 0. Only rst exits. en and clear_i ignored.
- alarm_src_o |= alarm_i on every event in any state except IDLE. alarm_count_o increments per event in any state except IDLE, saturates at 255.
- clear_i: honoured only in IDLE/MONITOR; clears alarm_src_o and alarm_count_o. Same-cycle event wins: count=1, src=that event's lanes.
- Escalation counter cleared only by rst.
- Asynchronous rst mid-operation: immediate return to reset values, outputs deasserted same instant.

Optional Feature:
GLITCH_RESP_IRQ_EN: adds output irq_o (1 bit), a one-cycle pulse on every counted event, plus input irq_mask_i that suppresses it. Without the macro neither port exists and event handling is unchanged.

Decomposition:
- Package clk_glitch_pkg: state enum resp_state_e (3-bit, values above), event-count width constant, saturation max (255).
- One sub-module clk_glitch_event_window: edge detect, window counter, window event count, threshold compare; outputs event pulse and threshold_hit. Top holds FSM, handshake, sticky status.

Test Plan:
- Single alarm_i=4'b0010 pulse in MONITOR -> alarm_count_o=1, alarm_src_o=4'b0010, state stays MONITOR.
- Two mismatch_i edges 10 cycles apart -> HALT 1 cycle after the 2nd is counted; halt_req_o=1; ack after 3 cycles -> core_rst_req_o high exactly 8 cycles, then MONITOR.
- Two events, no ack -> halt_req_o high 16 cycles, then RESET.
- Events at window cycles 10 and 300 (different windows) -> no HALT; window count=1 after the 2nd.
- Three full HALT/RESET incidents -> LOCKED, locked_o=1, fetch_block_o=1; en toggle and clear_i have no effect; only rst exits.
- 300 events with en held 1 and ack tied 0 over 3 incidents -> alarm_count_o saturates at 255. rst asserted mid-RESET -> all outputs 0 immediately.

Source files
------------

// File: rtl/clk_glitch_pkg.sv
// Shared types and constants for the clock-glitch responder.
//   resp_state_e    : responder FSM state, 3-bit encoding visible on state_o
//   EVT_CNT_W       : width of every event counter (window and total)
//   EVT_CNT_MAX     : saturation value of the event counters
//   resp_out_t      : the four control outputs driven by the FSM
//   state_outputs() : control-output pattern that belongs to each state
package clk_glitch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MONITOR = 3'd1,
    ST_HALT    = 3'd2,
    ST_RESET   = 3'd3,
    ST_LOCKED  = 3'd4
  } resp_state_e;

  localparam int                   EVT_CNT_W   = 8;
  localparam logic [EVT_CNT_W-1:0] EVT_CNT_MAX = 8'd255;

  typedef struct packed {
    logic halt_req;
    logic fetch_block;
    logic core_rst_req;
    logic locked;
  } resp_out_t;

  // Outputs are registered together with the state, so the FSM loads the
  // pattern of the state it is entering.
  function automatic resp_out_t state_outputs(input resp_state_e s);
    resp_out_t o;
    o = '0;
    case (s)
      ST_HALT: begin
        o.halt_req    = 1'b1;
        o.fetch_block = 1'b1;
      end
      ST_RESET: begin
        o.core_rst_req = 1'b1;
        o.fetch_block  = 1'b1;
      end
      ST_LOCKED: begin
        o.fetch_block = 1'b1;
        o.locked      = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/clk_glitch_event_window.sv
// Event detection and windowed event counting.
//   clk, rst         : clock, asynchronous active-high reset
//   run              : high while the responder is monitoring; low holds the
//                      window position and window count at zero
//   alarm_i          : per-lane alarm levels from the detector
//   mismatch_i       : detector mismatch level
//   event_o          : one-cycle pulse on each rising edge of any alarm source
//   threshold_hit_o  : window count has reached ALARM_THRESHOLD
module clk_glitch_event_window
  import clk_glitch_pkg::*;
#(
  parameter int NUMBER_OF_CLK   = 4,
  parameter int ALARM_THRESHOLD = 2,
  parameter int WINDOW_CYCLES   = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [NUMBER_OF_CLK-1:0] alarm_i,
  input  logic                     mismatch_i,
  output logic                     event_o,
  output logic                     threshold_hit_o
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);

  logic                 raw;
  logic                 raw_q;
  logic [WIN_W-1:0]     win_pos;
  logic [EVT_CNT_W-1:0] win_evt;

  assign raw     = (|alarm_i) | mismatch_i;
  // A held level produces a single event: only the low-to-high step counts.
  assign event_o = raw & ~raw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q <= 1'b0;
    end else begin
      raw_q <= raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_pos <= '0;
      win_evt <= '0;
    end else if (!run) begin
      win_pos <= '0;
      win_evt <= '0;
    end else begin
      // WINDOW_CYCLES is a power of two, so the position wraps on its own.
      win_pos <= win_pos + 1'b1;
      if (win_pos == WIN_W'(WINDOW_CYCLES - 1)) begin
        // An event in the last cycle of a window opens the next window.
        win_evt <= {{(EVT_CNT_W-1){1'b0}}, event_o};
      end else if (event_o && (win_evt != EVT_CNT_MAX)) begin
        win_evt <= win_evt + 1'b1;
      end
    end
  end

  assign threshold_hit_o = run && (win_evt >= EVT_CNT_W'(ALARM_THRESHOLD));

endmodule

// File: rtl/clk_glitch_responder.sv
// Graded core response to clock-glitch alarms.
// Counts alarm events per window; on reaching the threshold it halts the core
// (halt_req_o/halt_ack_i), pulses a core reset request, and after
// MAX_ESCALATIONS completed resets locks out permanently until rst.
//   clk, rst        : clock, asynchronous active-high reset
//   en              : enables monitoring (ignored in HALT/RESET/LOCKED)
//   alarm_i         : per-lane alarm levels
//   mismatch_i      : detector mismatch level
//   clear_i         : clears alarm_src_o/alarm_count_o in IDLE or MONITOR
//   halt_ack_i      : core acknowledges the halt request
//   halt_req_o      : halt request to the core
//   fetch_block_o   : blocks instruction fetch
//   core_rst_req_o  : core reset request, RESET_HOLD cycles long
//   locked_o        : permanent lockout indicator
//   alarm_src_o     : sticky OR of lanes seen on counted events
//   alarm_count_o   : total counted events, saturating at 255
//   state_o         : current FSM state (resp_state_e encoding)
// Optional build macro GLITCH_RESP_IRQ_EN adds irq_mask_i and irq_o, a
// one-cycle pulse for every counted event unless masked.
module clk_glitch_responder
  import clk_glitch_pkg::*;
#(
  parameter int NUMBER_OF_CLK   = 4,
  parameter int ALARM_THRESHOLD = 2,
  parameter int WINDOW_CYCLES   = 256,
  parameter int HALT_TIMEOUT    = 16,
  parameter int RESET_HOLD      = 8,
  parameter int MAX_ESCALATIONS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUMBER_OF_CLK-1:0] alarm_i,
  input  logic                     mismatch_i,
  input  logic                     clear_i,
  input  logic                     halt_ack_i,
  output logic                     halt_req_o,
  output logic                     fetch_block_o,
  output logic                     core_rst_req_o,
  output logic                     locked_o,
  output logic [NUMBER_OF_CLK-1:0] alarm_src_o,
  output logic [EVT_CNT_W-1:0]     alarm_count_o,
`ifdef GLITCH_RESP_IRQ_EN
  input  logic                     irq_mask_i,
  output logic                     irq_o,
`endif
  output logic [2:0]               state_o
);

  localparam int HALT_W = $clog2(HALT_TIMEOUT + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam int ESC_W  = $clog2(MAX_ESCALATIONS + 1);

  resp_state_e       state;
  resp_out_t         outs;
  logic [HALT_W-1:0] halt_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ESC_W-1:0]  esc_cnt;
  logic              event_pulse;
  logic              threshold_hit;
  logic              counted;
  logic              clear_ok;

  clk_glitch_event_window #(
    .NUMBER_OF_CLK   (NUMBER_OF_CLK),
    .ALARM_THRESHOLD (ALARM_THRESHOLD),
    .WINDOW_CYCLES   (WINDOW_CYCLES)
  ) u_window (
    .clk             (clk),
    .rst             (rst),
    .run             (state == ST_MONITOR),
    .alarm_i         (alarm_i),
    .mismatch_i      (mismatch_i),
    .event_o         (event_pulse),
    .threshold_hit_o (threshold_hit)
  );

  // Halt handshake: halt_req_o rises on entry to HALT and stays high until
  // the first cycle halt_ack_i is sampled high (or the timeout expires); the
  // request drops on the following edge. The core may hold ack as long as it
  // likes; ack outside HALT is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      outs     <= '0;
      halt_cnt <= '0;
      hold_cnt <= '0;
      esc_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            state <= ST_MONITOR;
            outs  <= state_outputs(ST_MONITOR);
          end
        end
        ST_MONITOR: begin
          if (!en) begin
            state <= ST_IDLE;
            outs  <= state_outputs(ST_IDLE);
          end else if (threshold_hit) begin
            state    <= ST_HALT;
            outs     <= state_outputs(ST_HALT);
            halt_cnt <= '0;
          end
        end
        ST_HALT: begin
          // An ack in the timeout cycle takes the same exit as the timeout.
          if (halt_ack_i || (halt_cnt == HALT_W'(HALT_TIMEOUT - 1))) begin
            state    <= ST_RESET;
            outs     <= state_outputs(ST_RESET);
            hold_cnt <= '0;
          end else begin
            halt_cnt <= halt_cnt + 1'b1;
          end
        end
        ST_RESET: begin
          if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
            esc_cnt <= esc_cnt + 1'b1;
            if (esc_cnt == ESC_W'(MAX_ESCALATIONS - 1)) begin
              state <= ST_LOCKED;
              outs  <= state_outputs(ST_LOCKED);
            end else begin
              state <= ST_MONITOR;
              outs  <= state_outputs(ST_MONITOR);
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          state <= ST_LOCKED;
          outs  <= state_outputs(ST_LOCKED);
        end
        default: begin
          state <= ST_IDLE;
          outs  <= '0;
        end
      endcase
    end
  end

  assign counted  = event_pulse && (state != ST_IDLE);
  assign clear_ok = clear_i && ((state == ST_IDLE) || (state == ST_MONITOR));

  // Sticky status. A clear coinciding with a counted event restarts the
  // record from that event instead of dropping it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_src_o   <= '0;
      alarm_count_o <= '0;
    end else if (counted) begin
      if (clear_ok) begin
        alarm_src_o   <= alarm_i;
        alarm_count_o <= EVT_CNT_W'(1);
      end else begin
        alarm_src_o <= alarm_src_o | alarm_i;
        if (alarm_count_o != EVT_CNT_MAX) begin
          alarm_count_o <= alarm_count_o + 1'b1;
        end
      end
    end else if (clear_ok) begin
      alarm_src_o   <= '0;
      alarm_count_o <= '0;
    end
  end

`ifdef GLITCH_RESP_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= counted && !irq_mask_i;
    end
  end
`endif

  assign halt_req_o     = outs.halt_req;
  assign fetch_block_o  = outs.fetch_block;
  assign core_rst_req_o = outs.core_rst_req;
  assign locked_o       = outs.locked;
  assign state_o        = state;

endmodule
